// File: rtl/chronos_pkg.sv
// Shared definitions for the Chronos RV32I pipeline control path.
package chronos_pkg;

  localparam int unsigned CTRL_STATE_W = 2;

  typedef enum logic [CTRL_STATE_W-1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake inputs and stall/flush controls exchanged with pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);

  logic                                load_use_haz;
  logic                                branch_taken_ex;
  logic                                mem_req;
  logic                                mem_ready;
  logic                                if_ready;
  logic                                pc_write;
  logic                                ifid_write;
  logic                                ifid_flush;
  logic                                idex_write;
  logic                                idex_bubble;
  logic                                exmem_write;
  logic                                memwb_bubble;
  logic [chronos_pkg::CTRL_STATE_W-1:0] state;
  logic                                mem_fault;
  logic [CNT_W-1:0]                    stall_cycles;

  // Pipeline side: supplies hazards/handshakes, consumes the controls.
  modport master (
    output load_use_haz, branch_taken_ex, mem_req, mem_ready, if_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           memwb_bubble, state, mem_fault, stall_cycles
  );

  modport slave (
    input  load_use_haz, branch_taken_ex, mem_req, mem_ready, if_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           memwb_bubble, state, mem_fault, stall_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: drives pipeline-register enables and bubbles from hazards,
// branch redirects and memory handshakes; tracks memory-wait timeouts and stall cycles.
module pipeline_ctrl
  import chronos_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned TmoW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  ctrl_state_t     state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            fault_q, fault_d;

  logic mem_stall, tmo_hit, freeze;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign tmo_hit   = (tmo_q == TmoW'(MEM_TIMEOUT));

  // MEM_WAIT holds until the access completes or the timeout forces release; in any
  // other state (including the illegal encoding) a mem stall freezes the pipe.
  assign freeze = (state_q == StMemWait) ? (mem_stall & ~tmo_hit) : mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = StRun;
    tmo_d   = '0;
    fault_d = fault_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
        end else if (bus.branch_taken_ex) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (mem_stall) begin
          state_d = StFlush;
        end
      end
      StMemWait: begin
        if (freeze) begin
          state_d = StMemWait;
          tmo_d   = tmo_q + TmoW'(1);
        end else begin
          if (mem_stall) begin
            fault_d = 1'b1;
          end
          if (bus.branch_taken_ex) begin
            state_d = StFlush;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_write   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (state_q == StFlush) begin
      // IF/ID holds the wrong-path fetch, so any load-use request is moot here.
      ifid_flush = 1'b1;
      pc_write   = bus.if_ready;
    end else if (bus.branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.load_use_haz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (!bus.if_ready) begin
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_write   = idex_write;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_write  = exmem_write;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.state        = state_q;
  assign bus.mem_fault    = fault_q;

  // Reset holds the counter clear, so cycles under reset never count.
  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (~pc_write),
    .count_o (bus.stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl with a small scoreboard queue.
module tb_pipeline_ctrl;

  localparam int unsigned CntW = 4;

  // Output vector order: {pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble}
  localparam logic [6:0] ON  = 7'b1101010;  // normal advance
  localparam logic [6:0] ORS = 7'b0010101;  // reset-forced
  localparam logic [6:0] OFZ = 7'b0000001;  // memory freeze
  localparam logic [6:0] OLU = 7'b0001110;  // load-use bubble
  localparam logic [6:0] OBR = 7'b1111110;  // branch redirect
  localparam logic [6:0] OFW = 7'b0111010;  // fetch wait / flush without fetch
  localparam logic [6:0] OFL = 7'b1111010;  // flush with fetch ready

  // Input vector order: {load_use, branch, mem_req, mem_ready, if_ready}
  localparam logic [4:0] IC  = 5'b00001;
  localparam logic [4:0] ILU = 5'b10001;
  localparam logic [4:0] IMS = 5'b00101;
  localparam logic [4:0] IMR = 5'b00111;
  localparam logic [4:0] INF = 5'b00000;

  typedef struct {
    string      name;
    logic [4:0] in;
    logic [6:0] outs;
    logic [1:0] st;
    logic       flt;
    logic [3:0] stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t vecs[32];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CntW)) bus ();

  pipeline_ctrl #(
    .CNT_W       (CntW),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(string n, logic [4:0] i, logic [6:0] o, logic [1:0] s,
                              logic f, logic [3:0] c);
    vec_t v;
    v.name = n; v.in = i; v.outs = o; v.st = s; v.flt = f; v.stall = c;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {bus.load_use_haz, bus.branch_taken_ex, bus.mem_req, bus.mem_ready, bus.if_ready} = v.in;
    sb_q.push_back(v);
  endtask

  task automatic compare_pop();
    vec_t       e;
    logic [6:0] got;
    e   = sb_q.pop_front();
    got = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write, bus.idex_bubble,
           bus.exmem_write, bus.memwb_bubble};
    n_vec++;
    if (got !== e.outs || bus.state !== e.st || bus.mem_fault !== e.flt ||
        bus.stall_cycles !== e.stall) begin
      n_fail++;
      $display("FAIL %s: got out=%b st=%0d flt=%b stall=%0d, want out=%b st=%0d flt=%b stall=%0d",
               e.name, got, bus.state, bus.mem_fault, bus.stall_cycles,
               e.outs, e.st, e.flt, e.stall);
    end
  endtask

  // One clock cycle: drive after the edge, check at the opposite edge.
  task automatic apply(input vec_t v);
    drive(v);
    @(negedge clk);
    compare_pop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("clean0",        IC,      ON,  2'd0, 1'b0, 4'd0);
    vecs[1]  = mk("clean1",        IC,      ON,  2'd0, 1'b0, 4'd0);
    vecs[2]  = mk("clean2",        IC,      ON,  2'd0, 1'b0, 4'd0);
    vecs[3]  = mk("clean3",        IC,      ON,  2'd0, 1'b0, 4'd0);
    vecs[4]  = mk("loaduse",       ILU,     OLU, 2'd0, 1'b0, 4'd0);
    vecs[5]  = mk("after_lu",      IC,      ON,  2'd0, 1'b0, 4'd1);
    vecs[6]  = mk("br_with_lu",    5'b11001, OBR, 2'd0, 1'b0, 4'd1);
    vecs[7]  = mk("flush_cycle",   IC,      OFL, 2'd1, 1'b0, 4'd1);
    vecs[8]  = mk("after_flush",   IC,      ON,  2'd0, 1'b0, 4'd1);
    vecs[9]  = mk("mem_stall0",    IMS,     OFZ, 2'd0, 1'b0, 4'd1);
    vecs[10] = mk("mem_wait1",     IMS,     OFZ, 2'd2, 1'b0, 4'd2);
    vecs[11] = mk("mem_wait2",     IMS,     OFZ, 2'd2, 1'b0, 4'd3);
    vecs[12] = mk("mem_release",   IMR,     ON,  2'd2, 1'b0, 4'd4);
    vecs[13] = mk("after_mem",     IC,      ON,  2'd0, 1'b0, 4'd4);
    vecs[14] = mk("fetch_wait",    INF,     OFW, 2'd0, 1'b0, 4'd4);
    vecs[15] = mk("after_fw",      IC,      ON,  2'd0, 1'b0, 4'd5);
    vecs[16] = mk("prio_mem",      5'b11101, OFZ, 2'd0, 1'b0, 4'd5);
    vecs[17] = mk("rel_branch",    5'b01111, OBR, 2'd2, 1'b0, 4'd6);
    vecs[18] = mk("flush_memstl",  IMS,     OFZ, 2'd1, 1'b0, 4'd6);
    vecs[19] = mk("flush_nofetch", 5'b10000, OFW, 2'd1, 1'b0, 4'd7);
    vecs[20] = mk("mem_stall_b",   IMS,     OFZ, 2'd0, 1'b0, 4'd8);
    vecs[21] = mk("rel_loaduse",   5'b10111, OLU, 2'd2, 1'b0, 4'd9);
    vecs[22] = mk("after_rel_lu",  IC,      ON,  2'd0, 1'b0, 4'd10);
    vecs[23] = mk("tmo_enter",     IMS,     OFZ, 2'd0, 1'b0, 4'd10);
    vecs[24] = mk("tmo_w0",        IMS,     OFZ, 2'd2, 1'b0, 4'd11);
    vecs[25] = mk("tmo_w1",        IMS,     OFZ, 2'd2, 1'b0, 4'd12);
    vecs[26] = mk("tmo_w2",        IMS,     OFZ, 2'd2, 1'b0, 4'd13);
    vecs[27] = mk("tmo_w3",        IMS,     OFZ, 2'd2, 1'b0, 4'd14);
    vecs[28] = mk("tmo_release",   IMS,     ON,  2'd2, 1'b0, 4'd15);
    vecs[29] = mk("fault_sticky",  IC,      ON,  2'd0, 1'b1, 4'd15);
    vecs[30] = mk("sat_fw",        INF,     OFW, 2'd0, 1'b1, 4'd15);
    vecs[31] = mk("sat_hold",      IC,      ON,  2'd0, 1'b1, 4'd15);

    rst_n = 1'b0;
    drive(mk("reset_state", IC, ORS, 2'd0, 1'b0, 4'd0));
    #1;
    compare_pop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted mid-MEM_WAIT aborts at once and clears fault and counters.
    apply(mk("pre_rst_stall", IMS, OFZ, 2'd0, 1'b1, 4'd15));
    apply(mk("pre_rst_wait",  IMS, OFZ, 2'd2, 1'b1, 4'd15));
    rst_n = 1'b0;
    drive(mk("rst_mid_wait", IMS, ORS, 2'd0, 1'b0, 4'd0));
    #1;
    compare_pop();
    repeat (2) @(posedge clk);
    #1;
    drive(mk("rst_hold_nocnt", IMS, ORS, 2'd0, 1'b0, 4'd0));
    compare_pop();
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk("rst_release", IC, ON, 2'd0, 1'b0, 4'd0));
    #1;
    compare_pop();
    @(posedge clk);
    #1;

    // Reset asserted mid-FLUSH returns to RUN immediately.
    apply(mk("branch_b", 5'b01001, OBR, 2'd0, 1'b0, 4'd0));
    rst_n = 1'b0;
    drive(mk("rst_mid_flush", IC, ORS, 2'd0, 1'b0, 4'd0));
    #1;
    compare_pop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk("post_flush_rst", IC, ON, 2'd0, 1'b0, 4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
